// File: rtl/if_fetch_pkg.sv
// Shared widths, defaults and fetch FSM state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF   = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: control from ID, instruction-memory handshake and the IF/ID triple.
interface if_fetch_if import if_fetch_pkg::*; #(
  parameter int unsigned ADDR_W = INST_ADDR_BUS,
  parameter int unsigned INST_W = INST_BUS
);

  logic              stall;
  logic              branchEn;
  logic [ADDR_W-1:0] branchTarget;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [INST_W-1:0] memData;
  logic [ADDR_W-1:0] ifPC;
  logic [INST_W-1:0] ifInst;
  logic              ifValid;

  modport master (
    input  stall, branchEn, branchTarget, memAck, memData,
    output memReq, memAddr, ifPC, ifInst, ifValid
  );

  modport slave (
    output stall, branchEn, branchTarget, memAck, memData,
    input  memReq, memAddr, ifPC, ifInst, ifValid
  );

endinterface

// File: rtl/if_fetch_pc_reg.sv
// Program counter with next-PC mux: redirect beats sequential advance; wraps modulo 2^ADDR_W.
module if_fetch_pc_reg import if_fetch_pkg::*; #(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_d
);

  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues word fetches, buffers one word across stalls,
// and drops fetches made stale by an ID redirect.
//   state      | meaning
//   FETCH_IDLE | no request outstanding; issue fetch at pc next edge
//   FETCH_REQ  | memReq high, memAddr frozen until memAck
//   FETCH_HOLD | acked word parked in hold buffer while stall is high
module if_fetch import if_fetch_pkg::*; #(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
  parameter int unsigned       INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input logic          clk,
  input logic          rst,
  if_fetch_if.master   bus
);

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic              pc_advance;
  logic [ADDR_W-1:0] pc_d;
  logic              present;
  logic [ADDR_W-1:0] present_pc;
  logic [INST_W-1:0] present_inst;

  // A redirect in the same cycle overrides the advance inside pc_reg.
  assign pc_advance = !bus.stall &&
                      (((state_q == FETCH_REQ) && bus.memAck && !kill_q) ||
                       (state_q == FETCH_HOLD));

  if_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (bus.branchEn),
    .redirect_pc (bus.branchTarget),
    .advance     (pc_advance),
    .pc_d        (pc_d)
  );

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    kill_d       = kill_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    present      = 1'b0;
    present_pc   = if_pc_q;
    present_inst = '0;
    unique case (state_q)
      FETCH_IDLE: begin
        state_d    = FETCH_REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = pc_d;
      end
      FETCH_REQ: begin
        if (bus.memAck) begin
          if (kill_q || bus.branchEn) begin
            kill_d     = 1'b0;
            mem_addr_d = pc_d;
          end else if (!bus.stall) begin
            present      = 1'b1;
            present_pc   = mem_addr_q;
            present_inst = bus.memData;
            mem_addr_d   = pc_d;
          end else begin
            hold_inst_d = bus.memData;
            hold_pc_d   = mem_addr_q;
            mem_req_d   = 1'b0;
            state_d     = FETCH_HOLD;
          end
        end else if (bus.branchEn) begin
          kill_d = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (bus.branchEn) begin
          state_d = FETCH_IDLE;
        end else if (!bus.stall) begin
          present      = 1'b1;
          present_pc   = hold_pc_q;
          present_inst = hold_inst_q;
          state_d      = FETCH_IDLE;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (!bus.stall) begin
      if_valid_d = present;
      if_inst_d  = present ? present_inst : '0;
      if (present) begin
        if_pc_d = present_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FETCH_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      kill_q      <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      kill_q      <= kill_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign bus.memReq  = mem_req_q;
  assign bus.memAddr = mem_addr_q;
  assign bus.ifPC    = if_pc_q;
  assign bus.ifInst  = if_inst_q;
  assign bus.ifValid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed stall/redirect/reset scenarios plus a
// second instance with a reset PC near the top of the address space.
module tb_if_fetch;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_vec = 0;
  int   n_bad = 0;
  int   lat   = 1;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp2_addr_q[$];

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) bus  ();
  if_fetch_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

  if_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_pres(input logic [31:0] pc, input logic [31:0] inst);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(inst);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      if (bus.memReq && bus.memAck && bus.memAddr == a) return;
      step();
    end
    n_vec++;
    n_bad++;
    $display("FAIL wait_ack: no ack for %h within 20 cycles", a);
  endtask

  // Instruction memory for dut: acks once a request has been seen for lat+1 cycles.
  initial begin : mem1
    int   age;
    logic prev_ack;
    age = 0;
    prev_ack = 1'b0;
    bus.memAck = 1'b0;
    bus.memData = 32'h0;
    forever begin
      @(negedge clk);
      if (!bus.memReq || prev_ack) age = 0;
      if (bus.memReq) age++;
      bus.memAck = bus.memReq && (age > lat);
      bus.memData = bus.memAck ? word_at(bus.memAddr) : 32'h0;
      prev_ack = bus.memAck;
    end
  end

  initial begin : mem2
    int   age;
    logic prev_ack;
    age = 0;
    prev_ack = 1'b0;
    bus2.memAck = 1'b0;
    bus2.memData = 32'h0;
    forever begin
      @(negedge clk);
      if (!bus2.memReq || prev_ack) age = 0;
      if (bus2.memReq) age++;
      bus2.memAck = bus2.memReq && (age > 1);
      bus2.memData = bus2.memAck ? word_at(bus2.memAddr) : 32'h0;
      prev_ack = bus2.memAck;
    end
  end

  // Monitor: models the output register and pops expectations on each new presentation.
  initial begin : mon
    logic        stall_prev, rst_prev, last_valid;
    logic [31:0] last_pc, last_inst, e_pc, e_inst, e_addr;
    stall_prev = 1'b0;
    rst_prev   = 1'b0;
    last_valid = 1'b0;
    last_pc    = 32'h0;
    last_inst  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_prev) begin
        check("rst_valid", 32'(bus.ifValid), 32'h0);
        check("rst_pc", bus.ifPC, 32'h0);
        check("rst_inst", bus.ifInst, 32'h0);
        check("rst_req", 32'(bus.memReq), 32'h0);
        check("rst_addr", bus.memAddr, 32'h0);
        last_valid = 1'b0;
        last_pc    = 32'h0;
        last_inst  = 32'h0;
      end else if (stall_prev) begin
        check("stall_valid", 32'(bus.ifValid), 32'(last_valid));
        check("stall_pc", bus.ifPC, last_pc);
        check("stall_inst", bus.ifInst, last_inst);
      end else if (bus.ifValid) begin
        if (exp_pc_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_present: got pc %h inst %h, none expected", bus.ifPC, bus.ifInst);
        end else begin
          e_pc   = exp_pc_q.pop_front();
          e_inst = exp_inst_q.pop_front();
          check("pres_pc", bus.ifPC, e_pc);
          check("pres_inst", bus.ifInst, e_inst);
          last_valid = 1'b1;
          last_pc    = e_pc;
          last_inst  = e_inst;
        end
      end else begin
        check("bubble_inst", bus.ifInst, 32'h0);
        check("bubble_pc", bus.ifPC, last_pc);
        last_valid = 1'b0;
        last_inst  = 32'h0;
      end
      if (bus.memReq && bus.memAck) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_fetch: got addr %h, none expected", bus.memAddr);
        end else begin
          e_addr = exp_addr_q.pop_front();
          check("fetch_addr", bus.memAddr, e_addr);
        end
      end
      stall_prev = bus.stall;
      rst_prev   = rst;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] e2;
    rst = 1'b0;
    rst2 = 1'b0;
    bus.stall = 1'b0;
    bus.branchEn = 1'b0;
    bus.branchTarget = 32'h0;
    bus2.stall = 1'b0;
    bus2.branchEn = 1'b0;
    bus2.branchTarget = 32'h0;
    repeat (3) step();

    // Sequential fetch with 1-cycle ack, then stall across the ack of 0x8.
    push_pres(32'h0000_0000, 32'hC0DE_0000);
    push_pres(32'h0000_0004, 32'hC0DE_0004);
    push_pres(32'h0000_0008, 32'hC0DE_0008);
    push_pres(32'h0000_000C, 32'hC0DE_000C);
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0008);
    exp_addr_q.push_back(32'h0000_000C);
    rst = 1'b1;
    wait_ack(32'h0);
    wait_ack(32'h4);
    check("gap_valid", 32'(bus.ifValid), 32'h0);
    check("gap_inst", bus.ifInst, 32'h0);
    step();
    bus.stall = 1'b1;
    step();
    step();
    check("hold_req", 32'(bus.memReq), 32'h0);
    step();
    check("hold_req2", 32'(bus.memReq), 32'h0);
    bus.stall = 1'b0;
    step();
    check("hold_pres_pc", bus.ifPC, 32'h8);
    check("idle_req", 32'(bus.memReq), 32'h0);
    step();
    check("after_hold_valid", 32'(bus.ifValid), 32'h0);
    check("next_req", 32'(bus.memReq), 32'h1);
    check("next_addr", bus.memAddr, 32'hC);

    // Redirect while 0x10 is outstanding; its data must never be presented.
    push_pres(32'h0000_0100, 32'hC0DE_0100);
    exp_addr_q.push_back(32'h0000_0010);
    exp_addr_q.push_back(32'h0000_0100);
    wait_ack(32'hC);
    lat = 2;
    step();
    bus.branchEn = 1'b1;
    bus.branchTarget = 32'h100;
    step();
    bus.branchEn = 1'b0;
    bus.branchTarget = 32'h0;
    lat = 1;
    check("kill_addr_stable", bus.memAddr, 32'h10);
    check("kill_req", 32'(bus.memReq), 32'h1);
    wait_ack(32'h10);
    step();
    check("redirect_addr", bus.memAddr, 32'h100);
    check("kill_valid", 32'(bus.ifValid), 32'h0);

    // Redirect in the same cycle as the ack of 0x104.
    push_pres(32'h0000_0200, 32'hC0DE_0200);
    exp_addr_q.push_back(32'h0000_0104);
    exp_addr_q.push_back(32'h0000_0200);
    wait_ack(32'h104);
    bus.branchEn = 1'b1;
    bus.branchTarget = 32'h200;
    step();
    bus.branchEn = 1'b0;
    bus.branchTarget = 32'h0;
    check("same_cycle_addr", bus.memAddr, 32'h200);
    check("same_cycle_valid", 32'(bus.ifValid), 32'h0);

    // Reset asserted while the ack of 0x204 arrives.
    exp_addr_q.push_back(32'h0000_0204);
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    push_pres(32'h0000_0000, 32'hC0DE_0000);
    push_pres(32'h0000_0004, 32'hC0DE_0004);
    wait_ack(32'h204);
    rst = 1'b0;
    step();
    check("rst_mid_req", 32'(bus.memReq), 32'h0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_req", 32'(bus.memReq), 32'h1);
    check("post_rst_addr", bus.memAddr, 32'h0);
    wait_ack(32'h4);
    step();
    rst = 1'b0;
    step();
    step();

    // Second instance: reset PC near the top, fetch addresses wrap to zero.
    exp2_addr_q.push_back(32'hFFFF_FFF8);
    exp2_addr_q.push_back(32'hFFFF_FFFC);
    exp2_addr_q.push_back(32'h0000_0000);
    rst2 = 1'b1;
    for (int i = 0; i < 20 && exp2_addr_q.size() > 0; i++) begin
      step();
      if (bus2.memReq && bus2.memAck) begin
        e2 = exp2_addr_q.pop_front();
        check("wrap_addr", bus2.memAddr, e2);
      end
    end
    check("wrap_left", 32'(exp2_addr_q.size()), 32'h0);
    rst2 = 1'b0;
    repeat (2) step();

    check("pres_left", 32'(exp_pc_q.size()), 32'h0);
    check("addr_left", 32'(exp_addr_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
